// File: rtl/lw_sha_msg_padder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lw_sha_msg_padder_if
// Purpose  : Handshake bundle for lw_sha_msg_padder. The upstream message
//            stream (data/valid/last/bytes/ready) and the downstream padded
//            block stream (data/valid/ready/block_last/msg_last) are carried
//            together.
// Modports : slave  - the padder: consumes the message, produces blocks
//            master - the environment: feeds the message, sinks blocks
// Ports    : in_data_i, in_valid_i, in_last_i, in_bytes_i, in_ready_o,
//            out_data_o, out_valid_o, out_ready_i, out_block_last_o,
//            out_msg_last_o (suffixes are from the padder's point of view)
// Revision : 1.0 - initial release
// ============================================================================
interface lw_sha_msg_padder_if #(
  parameter int WORD_SIZE = 32
);
  localparam int BW = $clog2(WORD_SIZE / 8) + 1;

  logic [WORD_SIZE-1:0] in_data_i;
  logic                 in_valid_i;
  logic                 in_last_i;
  logic [BW-1:0]        in_bytes_i;
  logic                 in_ready_o;
  logic [WORD_SIZE-1:0] out_data_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 out_block_last_o;
  logic                 out_msg_last_o;

  modport slave (
    input  in_data_i, in_valid_i, in_last_i, in_bytes_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, out_block_last_o, out_msg_last_o
  );

  modport master (
    output in_data_i, in_valid_i, in_last_i, in_bytes_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, out_block_last_o, out_msg_last_o
  );
endinterface
`default_nettype wire

// File: rtl/lw_sha_msg_padder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lw_sha_msg_padder
// Purpose  : SHA-2 message padder. Accepts message words (byte count on the
//            last word) and emits whole 16-word blocks: message bytes, a
//            0x80 pad byte, zero fill and a 2-word big-endian bit length.
//            One registered output stage, valid/ready on both sides.
// Params   : WORD_SIZE - 32 (SHA-224/256) or 64 (SHA-384/512)
// Ports    : clk_i    - clock, rising edge
//            reset_i  - synchronous reset, active-high
//            abort_i  - synchronous flush of the current message
//            bus      - lw_sha_msg_padder_if.slave (input/output streams)
//            busy_o   - padding in progress or output word pending
// Revision : 1.0 - initial release
// ============================================================================
module lw_sha_msg_padder #(
  parameter int WORD_SIZE = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  abort_i,
  lw_sha_msg_padder_if.slave    bus,
  output logic                  busy_o
);

  localparam int NB = WORD_SIZE / 8;
  localparam int LW = 2 * WORD_SIZE;
  // Byte counter width: bit length is byte_cnt*8 modulo 2^LW, so the top
  // three bits of a full LW-bit byte counter could never reach the output.
  localparam int CW = LW - 3;

  typedef enum logic [2:0] {
    ST_DATA   = 3'd0,
    ST_PAD80  = 3'd1,
    ST_ZERO   = 3'd2,
    ST_LEN_HI = 3'd3,
    ST_LEN_LO = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [CW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [WORD_SIZE-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 block_last_q, block_last_d;
  logic                 msg_last_q, msg_last_d;

  logic                 load;
  logic                 in_ready;
  logic                 emit;
  logic [WORD_SIZE-1:0] emit_word;
  logic [WORD_SIZE-1:0] tail_word;
  logic [LW-1:0]        bitlen;

  assign load   = !out_valid_q || bus.out_ready_i;
  assign bitlen = {byte_cnt_q, 3'b000};

  // Short last word: keep the leading k bytes, put 0x80 in byte k, zero the rest.
  always_comb begin
    tail_word = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < int'(bus.in_bytes_i)) begin
        tail_word[WORD_SIZE-1-8*b -: 8] = bus.in_data_i[WORD_SIZE-1-8*b -: 8];
      end else if (b == int'(bus.in_bytes_i)) begin
        tail_word[WORD_SIZE-1-8*b -: 8] = 8'h80;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    byte_cnt_d   = byte_cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    block_last_d = block_last_q;
    msg_last_d   = msg_last_q;
    in_ready     = 1'b0;
    emit         = 1'b0;
    emit_word    = '0;

    case (state_q)
      ST_DATA: begin
        in_ready = load;
        if (load && bus.in_valid_i) begin
          emit = 1'b1;
          if (!bus.in_last_i || int'(bus.in_bytes_i) >= NB) begin
            emit_word  = bus.in_data_i;
            byte_cnt_d = byte_cnt_q + CW'(NB);
            if (bus.in_last_i) begin
              state_d = ST_PAD80;
            end
          end else begin
            emit_word  = tail_word;
            byte_cnt_d = byte_cnt_q + CW'(bus.in_bytes_i);
            state_d    = (wcnt_q == 4'd13) ? ST_LEN_HI : ST_ZERO;
          end
        end
      end
      ST_PAD80: begin
        if (load) begin
          emit      = 1'b1;
          emit_word = {8'h80, {(WORD_SIZE-8){1'b0}}};
          state_d   = (wcnt_q == 4'd13) ? ST_LEN_HI : ST_ZERO;
        end
      end
      ST_ZERO: begin
        // Zero fill runs until word 13 of some block, wrapping into an extra
        // block when the pad byte landed in words 14/15.
        if (load) begin
          emit = 1'b1;
          if (wcnt_q == 4'd13) begin
            state_d = ST_LEN_HI;
          end
        end
      end
      ST_LEN_HI: begin
        if (load) begin
          emit      = 1'b1;
          emit_word = bitlen[LW-1:WORD_SIZE];
          state_d   = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (load) begin
          emit       = 1'b1;
          emit_word  = bitlen[WORD_SIZE-1:0];
          byte_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      default: begin
        state_d = ST_DATA;
      end
    endcase

    // Output register: refill when empty or drained; hold otherwise.
    if (load) begin
      out_valid_d = emit;
      if (emit) begin
        out_data_d   = emit_word;
        block_last_d = (wcnt_q == 4'd15);
        msg_last_d   = (state_q == ST_LEN_LO);
        wcnt_d       = wcnt_q + 4'd1;
      end else begin
        block_last_d = 1'b0;
        msg_last_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || abort_i) begin
      state_q      <= ST_DATA;
      wcnt_q       <= '0;
      byte_cnt_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      block_last_q <= 1'b0;
      msg_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      byte_cnt_q   <= byte_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      block_last_q <= block_last_d;
      msg_last_q   <= msg_last_d;
    end
  end

  assign bus.in_ready_o       = in_ready;
  assign bus.out_data_o       = out_data_q;
  assign bus.out_valid_o      = out_valid_q;
  assign bus.out_block_last_o = block_last_q;
  assign bus.out_msg_last_o   = msg_last_q;
  assign busy_o               = (state_q != ST_DATA) || out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_lw_sha_msg_padder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lw_sha_msg_padder
// Purpose  : Directed self-checking bench for lw_sha_msg_padder, W=32 and
//            W=64 instances side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lw_sha_msg_padder;

  logic clk = 1'b0;
  logic reset;
  logic abort32;
  logic abort64;
  logic busy32;
  logic busy64;

  always #5 clk = ~clk;

  lw_sha_msg_padder_if #(.WORD_SIZE(32)) bus32 ();
  lw_sha_msg_padder_if #(.WORD_SIZE(64)) bus64 ();

  lw_sha_msg_padder #(.WORD_SIZE(32)) u_dut32 (
    .clk_i   (clk),
    .reset_i (reset),
    .abort_i (abort32),
    .bus     (bus32),
    .busy_o  (busy32)
  );

  lw_sha_msg_padder #(.WORD_SIZE(64)) u_dut64 (
    .clk_i   (clk),
    .reset_i (reset),
    .abort_i (abort64),
    .bus     (bus64),
    .busy_o  (busy64)
  );

  typedef struct {
    logic [63:0] d;
    logic        bl;
    logic        ml;
  } cap_t;

  cap_t        cap32[$];
  cap_t        cap64[$];
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;

  // Record every transferred output word; handshake is judged mid-cycle.
  always @(negedge clk) begin
    cap_t c;
    if (bus32.out_valid_o && bus32.out_ready_i) begin
      c.d  = {32'h0, bus32.out_data_o};
      c.bl = bus32.out_block_last_o;
      c.ml = bus32.out_msg_last_o;
      cap32.push_back(c);
    end
    if (bus64.out_valid_o && bus64.out_ready_i) begin
      c.d  = bus64.out_data_o;
      c.bl = bus64.out_block_last_o;
      c.ml = bus64.out_msg_last_o;
      cap64.push_back(c);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input logic [63:0] d);
    exp_q.push_back(d);
  endtask

  task automatic exp_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(64'h0);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the word was taken.
  task automatic send(input bit w64, input logic [63:0] d, input bit last, input int k);
    int g;
    g = 0;
    if (w64) begin
      bus64.in_data_i  = d;
      bus64.in_last_i  = last;
      bus64.in_bytes_i = 4'(k);
      bus64.in_valid_i = 1'b1;
    end else begin
      bus32.in_data_i  = d[31:0];
      bus32.in_last_i  = last;
      bus32.in_bytes_i = 3'(k);
      bus32.in_valid_i = 1'b1;
    end
    @(negedge clk);
    while (!(w64 ? bus64.in_ready_o : bus32.in_ready_o) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("send accept", 64'(w64 ? bus64.in_ready_o : bus32.in_ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus32.in_valid_i = 1'b0;
    bus64.in_valid_i = 1'b0;
  endtask

  // Wait for the expected number of words, then compare words and flags.
  task automatic finish_msg(input bit w64, input string tag);
    int g;
    int n;
    cap_t c;
    g = 0;
    while ((w64 ? cap64.size() : cap32.size()) < exp_q.size() && g < 1000) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    n = w64 ? cap64.size() : cap32.size();
    check($sformatf("%s count", tag), 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      c = w64 ? cap64[i] : cap32[i];
      check($sformatf("%s data[%0d]", tag, i), c.d, exp_q[i]);
      check($sformatf("%s flags[%0d]", tag, i), 64'({c.bl, c.ml}),
            64'({(i % 16) == 15, i == exp_q.size() - 1}));
    end
    cap32.delete();
    cap64.delete();
    exp_q.delete();
    sync();
  endtask

  task automatic exp_abc32();
    exp_word(64'h61626380);
    exp_zeros(13);
    exp_word(64'h0);
    exp_word(64'h18);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] snap;
    reset = 1'b1;
    abort32 = 1'b0;
    abort64 = 1'b0;
    bus32.in_data_i = '0; bus32.in_valid_i = 1'b0; bus32.in_last_i = 1'b0;
    bus32.in_bytes_i = '0; bus32.out_ready_i = 1'b1;
    bus64.in_data_i = '0; bus64.in_valid_i = 1'b0; bus64.in_last_i = 1'b0;
    bus64.in_bytes_i = '0; bus64.out_ready_i = 1'b1;
    repeat (3) sync();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst out_valid", 64'(bus32.out_valid_o), 64'd0);
    check("rst out_data", 64'(bus32.out_data_o), 64'd0);
    check("rst last flags", 64'({bus32.out_block_last_o, bus32.out_msg_last_o}), 64'd0);
    check("rst busy", 64'(busy32), 64'd0);
    check("rst in_ready", 64'(bus32.in_ready_o), 64'd1);
    sync();

    // "abc"
    send(0, 64'h61626300, 1, 3);
    exp_abc32();
    finish_msg(0, "abc32");

    // Empty message; the data bytes must be masked away
    send(0, 64'hDEADBEEF, 1, 0);
    exp_word(64'h80000000);
    exp_zeros(13);
    exp_word(64'h0);
    exp_word(64'h0);
    finish_msg(0, "empty32");

    // Short last word lands at word 13: length follows immediately (53 bytes)
    for (int i = 0; i < 13; i++) begin
      send(0, 64'hA0000000 + 64'(i), 0, 0);
      exp_word(64'hA0000000 + 64'(i));
    end
    send(0, 64'hC1C2C3C4, 1, 1);
    exp_word(64'hC1800000);
    exp_word(64'h0);
    exp_word(64'h1A8);
    finish_msg(0, "w13_32");

    // 56 bytes: pad word at word 14 forces a second block
    for (int i = 0; i < 13; i++) begin
      send(0, 64'h01010101 * 64'(i + 1), 0, 0);
      exp_word(64'h01010101 * 64'(i + 1));
    end
    send(0, 64'h0E0E0E0E, 1, 4);
    exp_word(64'h0E0E0E0E);
    exp_word(64'h80000000);
    exp_word(64'h0);
    exp_zeros(14);
    exp_word(64'h0);
    exp_word(64'h1C0);
    finish_msg(0, "56B32");

    // Backpressure mid-block: output held, input stalled, nothing lost
    fork
      begin
        send(0, 64'h11223344, 0, 0);
        send(0, 64'h55667788, 0, 0);
        send(0, 64'h99AABBCC, 1, 2);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus32.out_ready_i = 1'b0;
        snap = {32'h0, bus32.out_data_o};
        repeat (5) begin
          @(negedge clk);
          check("bp data stable", {32'h0, bus32.out_data_o}, snap);
          check("bp valid held", 64'(bus32.out_valid_o), 64'd1);
          check("bp in_ready", 64'(bus32.in_ready_o), 64'd0);
        end
        @(posedge clk);
        #1;
        bus32.out_ready_i = 1'b1;
      end
    join
    exp_word(64'h11223344);
    exp_word(64'h55667788);
    exp_word(64'h99AA8000);
    exp_zeros(11);
    exp_word(64'h0);
    exp_word(64'h50);
    finish_msg(0, "bp32");

    // Abort during zero fill (output register holds word 7)
    send(0, 64'h61626300, 1, 3);
    repeat (7) @(posedge clk);
    #1;
    abort32 = 1'b1;
    sync();
    abort32 = 1'b0;
    check("abort out_valid", 64'(bus32.out_valid_o), 64'd0);
    check("abort busy", 64'(busy32), 64'd0);
    check("abort out_data", 64'(bus32.out_data_o), 64'd0);
    check("abort in_ready", 64'(bus32.in_ready_o), 64'd1);
    cap32.delete();
    send(0, 64'h61626300, 1, 3);
    exp_abc32();
    finish_msg(0, "abc32 after abort");

    // W=64 "abc"
    send(1, 64'h6162630000000000, 1, 3);
    exp_word(64'h6162638000000000);
    exp_zeros(13);
    exp_word(64'h0);
    exp_word(64'h18);
    finish_msg(1, "abc64");

    // Reset pulse mid-DATA
    send(1, 64'h0102030405060708, 0, 0);
    check("pre-rst valid64", 64'(bus64.out_valid_o), 64'd1);
    reset = 1'b1;
    sync();
    reset = 1'b0;
    check("rst64 out_valid", 64'(bus64.out_valid_o), 64'd0);
    check("rst64 out_data", bus64.out_data_o, 64'd0);
    check("rst64 last flags", 64'({bus64.out_block_last_o, bus64.out_msg_last_o}), 64'd0);
    check("rst64 busy", 64'(busy64), 64'd0);
    cap64.delete();

    // Full last word after reset: byte count must restart at zero (8 bytes)
    send(1, 64'h1111111111111111, 1, 8);
    exp_word(64'h1111111111111111);
    exp_word(64'h8000000000000000);
    exp_zeros(12);
    exp_word(64'h0);
    exp_word(64'h40);
    finish_msg(1, "full64");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
